light_pwm_dimmer: RTL and testbench
===================================

Name: light_pwm_dimmer

Overview:
Multi-channel lamp dimmer and successor to the combinational 4-bit light-level controller. Each channel takes a LEVEL_W-bit brightness target and drives one PWM lamp output. Optional soft ramping moves the level one step at a time toward the target. Level changes reach the PWM comparator only at period boundaries, so outputs stay glitch-free. The block sits between the automation control logic (level requests) and the lamp drivers.

Parameters:
CH, 4, number of independent lamp channels.
LEVEL_W, 4, brightness width; MAX = 2^LEVEL_W - 1 (15 at default).
RAMP_DIV, 16, clock cycles per ramp step (>= 1).

Ports:
clk  in  1  system clock; the only clock.
rst_n  in  1  reset, synchronous, active-low; sampled on rising clk.
en  in  1  global enable; 0 freezes all state and forces pwm_out to 0.
load  in  1  single-cycle strobe; latches target into all channel target registers.
target  in  CH*LEVEL_W  requested levels; channel i at bits [i*LEVEL_W +: LEVEL_W].
ramp_en  in  1  1 = step toward target at the ramp rate; 0 = jump to target.
pwm_out  out  CH  PWM lamp drive, one bit per channel.
level_out  out  CH*LEVEL_W  current (ramped) level per channel, same packing as target.
busy  out  1  1 while any channel's current level differs from its target.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Targets, current levels, compare levels, PWM counter and ramp divider are all cleared to 0.
  - pwm_out=0, level_out=0, busy=0.
  - Reset applied mid-ramp or mid-period aborts it immediately.
- en=0:
  - All registers hold, except that load still latches targets.
  - pwm_out is forced to 0 combinationally from en.
  - When en returns to 1, operation resumes from the held state.
- Load: target is captured into tgt[i] on the clk edge where load=1 (and en is don't-care). The ramp divider clears on that same edge.
- PWM:
  - Shared counter cnt runs 0..MAX-1 and wraps to 0, advancing each clock while en=1. Period = MAX clocks (15 at default).
  - pwm_out[i] = en & (cnt < cmp[i]) when cmp[i] < MAX.
  - cmp[i]=0 gives constant 0; cmp[i]=MAX gives constant 1.
  - Duty is cmp[i]/MAX. High phase is at the start of each period.
  - cmp[i] loads cur[i] on the edge where cnt wraps MAX-1 -> 0, and at no other time.
- Ramp, ramp_en=1:
  - Divider div counts 0..RAMP_DIV-1 while en=1. The tick is the edge where div==RAMP_DIV-1; div then wraps to 0.
  - On a tick, each channel's cur[i] moves ±1 toward tgt[i], or holds if equal.
  - Each channel has a state derived from cur vs tgt: HOLD (cur==tgt), UP (cur<tgt), DOWN (cur>tgt). Transitions are re-evaluated every cycle.
- Ramp, ramp_en=0: cur[i] <= tgt[i] on the next edge with en=1. This is immediate with no divider wait.
- Retarget mid-ramp: a new load replaces tgt. The ramp continues from the present cur, reversing direction if required, with no restart from 0.
- Simultaneous load and tick on the same edge: the load wins and the divider clears. cur does not step on that edge; it steps toward the new tgt from the next tick.
- Width and range:
  - cur is never incremented past MAX or decremented below 0. No wrap-around is permitted.
  - Arithmetic is unsigned, LEVEL_W bits.
- Outputs:
  - level_out = cur, registered.
  - busy = OR over channels of (cur[i] != tgt[i]), registered, valid one clock after the change.
- Channels are fully independent apart from the shared cnt, div, en and ramp_en.

Test Plan (CH=4, LEVEL_W=4, RAMP_DIV=4):
1. Reset, then hold rst_n=0 for 3 cycles with random inputs -> pwm_out=0000, level_out=0, busy=0 throughout.
2. ramp_en=0, load target ch0=5, ch1=0, ch2=15, ch3=8:
   - level_out updates one clock after load.
   - From the first full period after the next cnt wrap: ch0 high 5 of every 15 clocks; ch1 constant 0; ch2 constant 1; ch3 high 8 of 15.
3. ramp_en=1, ch0 from 0 to target 15:
   - busy rises one clock after the load.
   - level_out ch0 increments by 1 every 4 clocks, reaching 15 exactly 60 clocks after the load edge.
   - busy falls one clock later.
4. ramp_en=1, ch0 ramping up to 12, retarget to 3 when ch0 level is 7:
   - ch0 steps 7, 6, 5, 4, 3 at 4-clock intervals, with the divider cleared at the load.
   - No glitch on pwm_out within any period.
5. en=0 for 20 clocks while ch1 ramps from 2 to 10:
   - pwm_out=0000 and level_out frozen for the whole gap.
   - After en=1, the ramp resumes from the frozen value.
6. Boundary checks:
   - load and tick on the same edge -> no step on that edge.
   - rst_n=0 mid-ramp at level 9 -> all state 0 on the next edge.
   - target=15 with ramp_en=1 from 14 -> exactly one step, never exceeding 15.

Source files
------------

// File: rtl/light_pwm_dimmer.sv
// light_pwm_dimmer -- multi-channel PWM lamp dimmer with optional soft ramp.
//
// Each channel holds a target level, a current (ramped) level and a compare
// level. The current level either jumps to the target (ramp_en=0) or steps by
// one toward it every RAMP_DIV clocks (ramp_en=1). The compare level feeding
// the PWM comparator is refreshed only when the shared period counter wraps,
// so a duty change never lands in the middle of a PWM period.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   en         global enable; 0 holds all state and forces pwm_out low
//   load       one-cycle strobe latching target into every channel
//   target     CH x LEVEL_W requested levels, channel i at [i*LEVEL_W +: LEVEL_W]
//   ramp_en    1 = step toward target at the ramp rate, 0 = jump
//   pwm_out    one PWM drive bit per channel
//   level_out  current level per channel, same packing as target
//   busy       registered OR over channels of (current != target)

// Per-channel slice: target/current/compare registers, ramp direction FSM and
// the PWM comparator.
module light_pwm_chan #(
  parameter int LEVEL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               load,
  input  logic               ramp_en,
  input  logic               tick,     // ramp step strobe (already qualified by en)
  input  logic               wrap,     // period counter wraps on this edge
  input  logic [LEVEL_W-1:0] tgt_in,
  input  logic [LEVEL_W-1:0] cnt,
  output logic [LEVEL_W-1:0] cur,
  output logic               pwm,
  output logic               diff      // current differs from target
);

  localparam logic [LEVEL_W-1:0] MAX = '1;
  localparam logic [LEVEL_W-1:0] ONE = LEVEL_W'(1);

  // Ramp direction is a pure function of (cur, tgt); it is registered from the
  // next-state values so it always describes the present cur_q/tgt_q pair.
  typedef enum logic [1:0] {HOLD, UP, DOWN} dir_e;

  logic [LEVEL_W-1:0] tgt_q, tgt_d;
  logic [LEVEL_W-1:0] cur_q, cur_d;
  logic [LEVEL_W-1:0] cmp_q, cmp_d;
  dir_e               dir_q, dir_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_q <= '0;
      cur_q <= '0;
      cmp_q <= '0;
      dir_q <= HOLD;
    end else begin
      tgt_q <= tgt_d;
      cur_q <= cur_d;
      cmp_q <= cmp_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    tgt_d = tgt_q;
    cur_d = cur_q;
    cmp_d = cmp_q;
    dir_d = dir_q;

    // Load is honoured even while disabled.
    if (load) tgt_d = tgt_in;

    if (en) begin
      if (!ramp_en) begin
        cur_d = tgt_q;
      end else if (tick && !load) begin
        // A load on the tick edge suppresses the step; stepping resumes
        // toward the new target from the next tick.
        unique case (dir_q)
          UP:      if (cur_q != MAX) cur_d = cur_q + ONE;
          DOWN:    if (cur_q != '0)  cur_d = cur_q - ONE;
          default: ;
        endcase
      end
      if (wrap) cmp_d = cur_q;
    end

    if (cur_d == tgt_d)     dir_d = HOLD;
    else if (cur_d < tgt_d) dir_d = UP;
    else                    dir_d = DOWN;
  end

  // cnt never reaches MAX, so cmp=MAX gives a constant high and cmp=0 a
  // constant low without special cases.
  assign pwm  = en & (cnt < cmp_q);
  assign cur  = cur_q;
  assign diff = (dir_q != HOLD);

endmodule

module light_pwm_dimmer #(
  parameter int CH       = 4,
  parameter int LEVEL_W  = 4,
  parameter int RAMP_DIV = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [CH*LEVEL_W-1:0] target,
  input  logic                  ramp_en,
  output logic [CH-1:0]         pwm_out,
  output logic [CH*LEVEL_W-1:0] level_out,
  output logic                  busy
);

  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [LEVEL_W-1:0] CNT_LAST = LEVEL_W'((1 << LEVEL_W) - 2);

  logic [LEVEL_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               busy_q, busy_d;

  logic [CH-1:0][LEVEL_W-1:0] tgt_w;
  logic [CH-1:0][LEVEL_W-1:0] cur_w;
  logic [CH-1:0]              diff_w;
  logic                       tick;
  logic                       wrap;

  assign tgt_w = target;
  assign tick  = en && (div_q == DIV_LAST);
  assign wrap  = en && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    busy_d = busy_q;
    if (en) begin
      cnt_d  = wrap ? '0 : cnt_q + LEVEL_W'(1);
      div_d  = tick ? '0 : div_q + DIV_W'(1);
      busy_d = |diff_w;
    end
    // Load restarts the ramp interval so the first step lands a full
    // RAMP_DIV clocks after the new target arrives.
    if (load) div_d = '0;
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    light_pwm_chan #(.LEVEL_W(LEVEL_W)) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .load    (load),
      .ramp_en (ramp_en),
      .tick    (tick),
      .wrap    (wrap),
      .tgt_in  (tgt_w[g]),
      .cnt     (cnt_q),
      .cur     (cur_w[g]),
      .pwm     (pwm_out[g]),
      .diff    (diff_w[g])
    );
  end

  assign level_out = cur_w;
  assign busy      = busy_q;

endmodule

// File: tb/tb_light_pwm_dimmer.sv
module tb_light_pwm_dimmer;

  localparam int CH = 4;
  localparam int LW = 4;
  localparam int RD = 4;
  localparam int MAX = (1 << LW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, en, load, ramp_en;
  logic [15:0]   target;
  logic [3:0]    pwm_out;
  logic [15:0]   level_out;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference state.
  int mtgt[CH], mcur[CH], mcmp[CH];
  int mcnt, mdiv;
  bit mbusy;

  light_pwm_dimmer #(.CH(CH), .LEVEL_W(LW), .RAMP_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .target(target),
    .ramp_en(ramp_en), .pwm_out(pwm_out), .level_out(level_out), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance the reference by one clock edge using the inputs present at it.
  task automatic model_edge();
    int  ntgt[CH], ncur[CH], ncmp[CH];
    int  ncnt, ndiv;
    bit  nbusy, tk, wr;
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin mtgt[i] = 0; mcur[i] = 0; mcmp[i] = 0; end
      mcnt = 0; mdiv = 0; mbusy = 0;
      return;
    end
    ntgt = mtgt; ncur = mcur; ncmp = mcmp;
    ncnt = mcnt; ndiv = mdiv; nbusy = mbusy;
    tk = en && (mdiv == RD - 1);
    wr = en && (mcnt == MAX - 1);
    if (en) begin
      ndiv  = (mdiv + 1) % RD;
      ncnt  = (mcnt + 1) % MAX;
      nbusy = 0;
      for (int i = 0; i < CH; i++) begin
        if (mcur[i] != mtgt[i]) nbusy = 1;
        if (!ramp_en) ncur[i] = mtgt[i];
        else if (tk && !load) begin
          if (mcur[i] < mtgt[i]) ncur[i] = mcur[i] + 1;
          else if (mcur[i] > mtgt[i]) ncur[i] = mcur[i] - 1;
        end
        if (wr) ncmp[i] = mcur[i];
      end
    end
    if (load) begin
      ndiv = 0;
      for (int i = 0; i < CH; i++) ntgt[i] = (target >> (i * LW)) & MAX;
    end
    mtgt = ntgt; mcur = ncur; mcmp = ncmp;
    mcnt = ncnt; mdiv = ndiv; mbusy = nbusy;
  endtask

  task automatic check_all();
    logic [15:0] elev;
    logic [3:0]  epwm;
    for (int i = 0; i < CH; i++) begin
      elev[i*LW +: LW] = 4'(mcur[i]);
      epwm[i] = en && (mcnt < mcmp[i]);
    end
    chk("level", 32'(level_out), 32'(elev));
    chk("pwm",   32'(pwm_out),   32'(epwm));
    chk("busy",  32'(busy),      32'(mbusy));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; load = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic do_load(input logic [15:0] t);
    target = t; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  int cnt_hi[CH];
  int guard, changes;
  logic [3:0] prev, expl;
  logic [15:0] frozen;

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0; ramp_en = 1'b0; target = '0;
    for (int i = 0; i < CH; i++) begin mtgt[i] = 0; mcur[i] = 0; mcmp[i] = 0; end
    mcnt = 0; mdiv = 0; mbusy = 0;
    #2;

    // 1: reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      en = 1'($urandom); load = 1'($urandom); ramp_en = 1'($urandom);
      target = 16'($urandom);
      step();
      chk("t1_pwm", 32'(pwm_out), 0);
      chk("t1_lvl", 32'(level_out), 0);
      chk("t1_busy", 32'(busy), 0);
    end
    en = 1'b1; load = 1'b0; rst_n = 1'b1;

    // 2: jump mode, duty per channel over one full period
    ramp_en = 1'b0;
    do_load(16'h8F05);
    chk("t2_lvl_load_edge", 32'(level_out), 0);
    step();
    chk("t2_lvl_next", 32'(level_out), 32'h8F05);
    guard = 0;
    do begin step(); guard++; end while (mcnt != 0 && guard < 40);
    for (int i = 0; i < CH; i++) cnt_hi[i] = 0;
    for (int k = 0; k < MAX; k++) begin
      for (int i = 0; i < CH; i++) cnt_hi[i] += int'(pwm_out[i]);
      step();
    end
    chk("t2_duty0", cnt_hi[0], 5);
    chk("t2_duty1", cnt_hi[1], 0);
    chk("t2_duty2", cnt_hi[2], 15);
    chk("t2_duty3", cnt_hi[3], 8);

    // 3: ramp 0 -> 15 on ch0
    do_reset();
    ramp_en = 1'b1;
    do_load(16'h000F);
    chk("t3_busy0", 32'(busy), 0);
    step();
    chk("t3_busy1", 32'(busy), 1);
    for (int k = 2; k <= 60; k++) begin
      step();
      if (k == 59) chk("t3_lvl59", 32'(level_out[3:0]), 14);
      if (k == 60) begin
        chk("t3_lvl60", 32'(level_out[3:0]), 15);
        chk("t3_busy60", 32'(busy), 1);
      end
    end
    step();
    chk("t3_busy61", 32'(busy), 0);

    // 4: retarget mid-ramp, reversing direction
    do_reset();
    ramp_en = 1'b1;
    do_load(16'h000C);
    guard = 0;
    while (mcur[0] != 7 && guard < 100) begin step(); guard++; end
    chk("t4_reach7", 32'(level_out[3:0]), 7);
    do_load(16'h0003);
    for (int k = 1; k <= 16; k++) begin
      step();
      expl = 4'(7 - k / 4);
      chk("t4_down", 32'(level_out[3:0]), 32'(expl));
    end

    // 5: enable gap during ramp on ch1
    do_reset();
    ramp_en = 1'b0;
    do_load(16'h0020);
    step();
    ramp_en = 1'b1;
    do_load(16'h00A0);
    repeat (6) step();
    for (int i = 0; i < CH; i++) frozen[i*LW +: LW] = 4'(mcur[i]);
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t5_pwm_off", 32'(pwm_out), 0);
      chk("t5_frozen", 32'(level_out), 32'(frozen));
    end
    en = 1'b1;
    guard = 0;
    while (mcur[1] != 10 && guard < 100) begin step(); guard++; end
    chk("t5_reach10", 32'(level_out[7:4]), 10);

    // 6a: load on the tick edge suppresses the step
    do_reset();
    ramp_en = 1'b1;
    do_load(16'h000F);
    guard = 0;
    while (!(mdiv == RD - 1 && mcur[0] >= 2) && guard < 100) begin step(); guard++; end
    expl = 4'(mcur[0]);
    do_load(16'h000F);
    chk("t6_loadtick", 32'(level_out[3:0]), 32'(expl));
    repeat (3) step();
    chk("t6_hold3", 32'(level_out[3:0]), 32'(expl));
    step();
    chk("t6_step4", 32'(level_out[3:0]), 32'(expl + 4'd1));

    // 6b: reset mid-ramp at level 9
    guard = 0;
    while (mcur[0] != 9 && guard < 100) begin step(); guard++; end
    chk("t6_reach9", 32'(level_out[3:0]), 9);
    do_reset();
    chk("t6_rst_lvl", 32'(level_out), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_pwm", 32'(pwm_out), 0);

    // 6c: 14 -> 15 takes exactly one step and stops
    ramp_en = 1'b0;
    do_load(16'h000E);
    step();
    ramp_en = 1'b1;
    do_load(16'h000F);
    changes = 0;
    prev = level_out[3:0];
    for (int k = 0; k < 20; k++) begin
      step();
      if (level_out[3:0] != prev) changes++;
      prev = level_out[3:0];
    end
    chk("t6_one_step", changes, 1);
    chk("t6_top", 32'(level_out[3:0]), 15);

    // Random traffic against the reference model
    ramp_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 9) != 0);
      load  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 31) == 0) ramp_en = ~ramp_en;
      target = 16'($urandom);
      step();
    end
    load = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
